// File: rtl/dcollide_mem_pkg.sv
// Shared constants and writer state encoding for the collision-detection sphere memory.
// The read-side consumer imports the same package, so both sides agree on record geometry.
package dcollide_mem_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int WORDS_PER_REC = 8;
  localparam int RAM_DEPTH     = 32;

  typedef logic [1:0] wr_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_ACK   = 2'd2;

endpackage

// File: rtl/sphere_record_writer.sv
// Serialises one 8-word sphere record into eight acknowledged single-word memory writes,
// tracking how many records are stored so the memory is never written past its depth.
module sphere_record_writer #(
  parameter int DATA_WIDTH    = dcollide_mem_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH    = 32,
  parameter int WORDS_PER_REC = dcollide_mem_pkg::WORDS_PER_REC,
  parameter int RAM_DEPTH     = dcollide_mem_pkg::RAM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rec_valid,
  output logic                  rec_ready,
  input  logic [DATA_WIDTH-1:0] rec_word0,
  input  logic [DATA_WIDTH-1:0] rec_word1,
  input  logic [DATA_WIDTH-1:0] rec_word2,
  input  logic [DATA_WIDTH-1:0] rec_word3,
  input  logic [DATA_WIDTH-1:0] rec_word4,
  input  logic [DATA_WIDTH-1:0] rec_word5,
  input  logic [DATA_WIDTH-1:0] rec_word6,
  input  logic [DATA_WIDTH-1:0] rec_word7,
  input  logic                  clear,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_write_done,
  output logic                  rec_done,
  output logic [ADDR_WIDTH-1:0] rec_count,
  output logic                  full
);
  import dcollide_mem_pkg::wr_state_t;
  import dcollide_mem_pkg::ST_IDLE;
  import dcollide_mem_pkg::ST_WRITE;
  import dcollide_mem_pkg::ST_ACK;

  localparam int                  K_W      = $clog2(WORDS_PER_REC);
  localparam logic [K_W-1:0]      K_LAST   = K_W'(WORDS_PER_REC - 1);
  localparam logic [ADDR_WIDTH-1:0] REC_CAP = ADDR_WIDTH'(RAM_DEPTH / WORDS_PER_REC);

  wr_state_t               r_state;
  logic [K_W-1:0]          r_k;
  logic [DATA_WIDTH-1:0]   r_buf [WORDS_PER_REC];
  logic                    r_rec_ready;
  logic                    r_mem_cs;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_data;
  logic                    r_rec_done;
  logic [ADDR_WIDTH-1:0]   r_rec_count;
  logic                    r_full;

  logic [DATA_WIDTH-1:0]   w_words [WORDS_PER_REC];
  logic                    w_accept;
  logic [K_W-1:0]          w_k_next;
  logic [ADDR_WIDTH-1:0]   w_count_inc;
  logic [ADDR_WIDTH-1:0]   w_base;

  assign w_words[0] = rec_word0;
  assign w_words[1] = rec_word1;
  assign w_words[2] = rec_word2;
  assign w_words[3] = rec_word3;
  assign w_words[4] = rec_word4;
  assign w_words[5] = rec_word5;
  assign w_words[6] = rec_word6;
  assign w_words[7] = rec_word7;

  // clear takes priority over a simultaneous record offer
  assign w_accept    = (r_state == ST_IDLE) && rec_valid && r_rec_ready && !clear;
  assign w_k_next    = r_k + K_W'(1);
  assign w_count_inc = r_rec_count + ADDR_WIDTH'(1);
  assign w_base      = r_rec_count * ADDR_WIDTH'(WORDS_PER_REC);

  genvar gi;
  generate
    for (gi = 0; gi < WORDS_PER_REC; gi++) begin : g_buf
      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_buf[gi] <= w_words[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_rec_ready <= 1'b1;
      r_mem_cs    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_rec_done  <= 1'b0;
      r_rec_count <= '0;
      r_full      <= 1'b0;
    end else begin
      r_rec_done <= 1'b0;
      r_mem_cs   <= 1'b0;
      r_mem_we   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_rec_count <= '0;
            r_full      <= 1'b0;
            r_rec_ready <= 1'b1;
          end else if (w_accept) begin
            // word 0 comes straight from the port; the buffer copy lands on the same edge
            r_k         <= '0;
            r_mem_addr  <= w_base;
            r_mem_data  <= w_words[0];
            r_mem_cs    <= 1'b1;
            r_mem_we    <= 1'b1;
            r_rec_ready <= 1'b0;
            r_state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          if (mem_write_done) begin
            if (r_k != K_LAST) begin
              r_k        <= w_k_next;
              r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
              r_mem_data <= r_buf[w_k_next];
              r_mem_cs   <= 1'b1;
              r_mem_we   <= 1'b1;
              r_state    <= ST_WRITE;
            end else begin
              r_rec_count <= w_count_inc;
              r_full      <= (w_count_inc == REC_CAP);
              r_rec_ready <= (w_count_inc != REC_CAP);
              r_rec_done  <= 1'b1;
              r_state     <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign rec_ready = r_rec_ready;
  assign mem_cs    = r_mem_cs;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign rec_done  = r_rec_done;
  assign rec_count = r_rec_count;
  assign full      = r_full;

endmodule

// File: tb/tb_sphere_record_writer.sv
// Directed bench for sphere_record_writer: a memory model acks each write one cycle later
// (optionally delayed for one address) and a monitor logs every write pulse.
module tb_sphere_record_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  logic [31:0] rec_word0 = '0, rec_word1 = '0, rec_word2 = '0, rec_word3 = '0;
  logic [31:0] rec_word4 = '0, rec_word5 = '0, rec_word6 = '0, rec_word7 = '0;
  logic        clear = 1'b0;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_data;
  logic        mem_write_done = 1'b0;
  logic        rec_done;
  logic [31:0] rec_count;
  logic        full;

  int tests = 0;
  int fails = 0;

  logic [31:0] wa[$];
  logic [31:0] wd[$];
  int          dbl = 0;
  logic        prev_we = 1'b0;
  int          pend = 0;
  int          slow_addr = -1;
  int          slow_extra = 3;

  sphere_record_writer dut (
    .clk(clk), .rst(rst), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_word0(rec_word0), .rec_word1(rec_word1), .rec_word2(rec_word2), .rec_word3(rec_word3),
    .rec_word4(rec_word4), .rec_word5(rec_word5), .rec_word6(rec_word6), .rec_word7(rec_word7),
    .clear(clear), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_write_done(mem_write_done), .rec_done(rec_done), .rec_count(rec_count), .full(full)
  );

  always #5 clk = ~clk;

  // memory model and write monitor
  always @(posedge clk) begin
    mem_write_done <= 1'b0;
    if (pend > 0) begin
      if (pend == 1) mem_write_done <= 1'b1;
      pend = pend - 1;
    end
    if (mem_cs && mem_we) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
      if (prev_we) dbl++;
      if (int'(mem_addr) == slow_addr) pend = slow_extra;
      else mem_write_done <= 1'b1;
    end
    prev_we = mem_we;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_words(input logic [31:0] w0);
    rec_word0 = w0;      rec_word1 = w0 + 1; rec_word2 = w0 + 2; rec_word3 = w0 + 3;
    rec_word4 = w0 + 4;  rec_word5 = w0 + 5; rec_word6 = w0 + 6; rec_word7 = w0 + 7;
  endtask

  // Called at a negedge. Offers a record, waits for acceptance, then counts cycles to rec_done.
  task automatic run_record(input logic [31:0] w0, input bit hold, input int clear_cyc,
                            input int chg_cyc, input logic [31:0] chg_w0, input bit chk_slow,
                            output int done_cyc, output int wait_cyc);
    int cyc;
    set_words(w0);
    rec_valid = 1'b1;
    wait_cyc = 0;
    while (!rec_ready && wait_cyc < 60) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (!rec_ready) begin
      check("accept_timeout", 64'(rec_ready), 64'd1);
      rec_valid = 1'b0;
      done_cyc = -1;
      return;
    end
    @(posedge clk);
    cyc = 0;
    done_cyc = -1;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (!hold && cyc == 1) rec_valid = 1'b0;
      if (cyc == clear_cyc) clear = 1'b1;
      if (cyc == clear_cyc + 1) clear = 1'b0;
      if (cyc == chg_cyc) set_words(chg_w0);
      if (chk_slow && cyc >= 12 && cyc <= 14) begin
        check("slow_addr_hold", 64'(mem_addr), 64'd5);
        check("slow_cs_low", 64'(mem_cs), 64'd0);
      end
      if (rec_done) begin
        done_cyc = cyc;
        break;
      end
    end
    clear = 1'b0;
  endtask

  initial begin
    int dc, wc, cs_seen;

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_cs", 64'(mem_cs), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", 64'(mem_data), 64'd0);
    check("rst_ready", 64'(rec_ready), 64'd1);
    check("rst_done", 64'(rec_done), 64'd0);
    check("rst_count", 64'(rec_count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    $display("[TB] reset checked");

    // single record with cycle-exact view of word 0
    wa.delete(); wd.delete(); dbl = 0;
    set_words(32'h11);
    rec_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rec_valid = 1'b0;
    check("c1_we", 64'(mem_we), 64'd1);
    check("c1_cs", 64'(mem_cs), 64'd1);
    check("c1_addr", 64'(mem_addr), 64'd0);
    check("c1_data", 64'(mem_data), 64'h11);
    check("c1_ready", 64'(rec_ready), 64'd0);
    @(negedge clk);
    check("c2_we", 64'(mem_we), 64'd0);
    check("c2_addr_hold", 64'(mem_addr), 64'd0);
    dc = 2;
    while (!rec_done && dc < 100) begin
      @(negedge clk);
      dc++;
    end
    check("single_done_cycle", 64'(dc), 64'd17);
    check("single_ready_back", 64'(rec_ready), 64'd1);
    check("single_count", 64'(rec_count), 64'd1);
    check("single_nwrites", 64'(wa.size()), 64'd8);
    for (int i = 0; i < 8 && i < wa.size(); i++) begin
      check("single_addr", 64'(wa[i]), 64'(i));
      check("single_data", 64'(wd[i]), 64'(32'h11 + i));
    end
    check("single_dbl_pulse", 64'(dbl), 64'd0);
    $display("[TB] single record done in cycle %0d, count=%0d", dc, rec_count);

    // fill the remaining three records back to back
    wa.delete(); wd.delete();
    run_record(32'h21, 1'b1, -10, -10, 32'h0, 1'b0, dc, wc);
    check("fill2_wait", 64'(wc), 64'd0);
    run_record(32'h31, 1'b1, -10, -10, 32'h0, 1'b0, dc, wc);
    run_record(32'h41, 1'b0, -10, -10, 32'h0, 1'b0, dc, wc);
    check("fill_nwrites", 64'(wa.size()), 64'd24);
    if (wa.size() == 24) begin
      check("fill_rec2_addr", 64'(wa[0]), 64'd8);
      check("fill_last_addr", 64'(wa[23]), 64'd31);
      check("fill_last_data", 64'(wd[23]), 64'h48);
    end
    check("fill_count", 64'(rec_count), 64'd4);
    check("fill_full", 64'(full), 64'd1);
    check("fill_ready", 64'(rec_ready), 64'd0);
    $display("[TB] fill done, count=%0d full=%0b", rec_count, full);

    // fifth record offered for 20 cycles while full
    set_words(32'h55);
    rec_valid = 1'b1;
    cs_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_cs) cs_seen++;
    end
    rec_valid = 1'b0;
    check("full_no_cs", 64'(cs_seen), 64'd0);
    check("full_count_hold", 64'(rec_count), 64'd4);
    $display("[TB] offer while full, cs cycles=%0d", cs_seen);

    // clear in IDLE
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_count", 64'(rec_count), 64'd0);
    check("clear_full", 64'(full), 64'd0);
    check("clear_ready", 64'(rec_ready), 64'd1);
    wa.delete(); wd.delete();
    run_record(32'h51, 1'b0, -10, -10, 32'h0, 1'b0, dc, wc);
    check("clear_rec_done", 64'(dc), 64'd17);
    if (wa.size() == 8) begin
      check("clear_first_addr", 64'(wa[0]), 64'd0);
      check("clear_last_addr", 64'(wa[7]), 64'd7);
    end else check("clear_nwrites", 64'(wa.size()), 64'd8);
    $display("[TB] record after clear written, count=%0d", rec_count);

    // clear during ACK is ignored
    wa.delete(); wd.delete();
    run_record(32'h61, 1'b0, 2, -10, 32'h0, 1'b0, dc, wc);
    check("ackclr_count", 64'(rec_count), 64'd2);
    if (wa.size() > 0) check("ackclr_first_addr", 64'(wa[0]), 64'd8);
    $display("[TB] clear during ACK, count=%0d", rec_count);

    // slow ack on word 5 of a record at base 0
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wa.delete(); wd.delete(); dbl = 0;
    slow_addr = 5;
    run_record(32'h71, 1'b0, -10, -10, 32'h0, 1'b1, dc, wc);
    slow_addr = -1;
    check("slow_done_cycle", 64'(dc), 64'd20);
    check("slow_nwrites", 64'(wa.size()), 64'd8);
    check("slow_dbl_pulse", 64'(dbl), 64'd0);
    check("slow_count", 64'(rec_count), 64'd1);
    $display("[TB] slow ack record done in cycle %0d", dc);

    // back-pressure: valid held, words change mid-transfer
    wa.delete(); wd.delete();
    run_record(32'h81, 1'b1, -10, 3, 32'h91, 1'b0, dc, wc);
    check("bp1_done_cycle", 64'(dc), 64'd17);
    check("bp1_nwrites", 64'(wa.size()), 64'd8);
    for (int i = 0; i < 8 && i < wd.size(); i++)
      check("bp1_data", 64'(wd[i]), 64'(32'h81 + i));
    wa.delete(); wd.delete();
    run_record(32'h91, 1'b0, -10, -10, 32'h0, 1'b0, dc, wc);
    check("bp2_wait", 64'(wc), 64'd0);
    check("bp2_done_cycle", 64'(dc), 64'd17);
    if (wa.size() == 8) begin
      check("bp2_first_addr", 64'(wa[0]), 64'd16);
      check("bp2_first_data", 64'(wd[0]), 64'h91);
      check("bp2_last_data", 64'(wd[7]), 64'h98);
    end else check("bp2_nwrites", 64'(wa.size()), 64'd8);
    check("bp_count", 64'(rec_count), 64'd3);
    $display("[TB] back-pressure pair written, count=%0d", rec_count);

    // reset during ACK of word 3
    wa.delete(); wd.delete();
    set_words(32'hA1);
    rec_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rec_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_we", 64'(mem_we), 64'd0);
    check("midrst_cs", 64'(mem_cs), 64'd0);
    check("midrst_count", 64'(rec_count), 64'd0);
    check("midrst_ready", 64'(rec_ready), 64'd1);
    check("midrst_nwrites", 64'(wa.size()), 64'd4);
    repeat (4) @(negedge clk);
    check("midrst_quiet", 64'(wa.size()), 64'd4);
    $display("[TB] reset mid-record, writes seen=%0d", wa.size());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sphere_record_writer.md
# sphere_record_writer

Write-side sequencer for the collision-detection sphere memory. Accepts one 8-word sphere record per handshake in parallel form and serialises it into eight single-word writes (chip select, write enable, address, data). Each write is paced by the memory's registered `write_done` acknowledge. It is the producer counterpart of the memory's 8-word-wide read port, and tracks the record fill level so records are never written past the memory depth.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: word width.
- `ADDR_WIDTH`, default 32: memory address width.
- `WORDS_PER_REC`, default 8: words per record. Fixed at 8; the port list depends on it.
- `RAM_DEPTH`, default 32: memory depth in words. Must be a multiple of `WORDS_PER_REC`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rec_valid` in 1: a record is offered on `rec_word0..7`.
- `rec_ready` out 1: the writer can accept a record.
- `rec_word0` … `rec_word7` in `DATA_WIDTH` each: record words; `rec_word0` goes to the lowest address.
- `clear` in 1: rewind the fill pointer to record 0. Honoured only in IDLE.
- `mem_cs` out 1: memory chip select.
- `mem_we` out 1: memory write enable.
- `mem_addr` out `ADDR_WIDTH`: write address.
- `mem_data` out `DATA_WIDTH`: write data.
- `mem_write_done` in 1: memory acknowledge, high for the cycle after a sampled write.
- `rec_done` out 1: one-cycle pulse when a record's last word is acknowledged.
- `rec_count` out `ADDR_WIDTH`: number of records stored since reset or `clear`.
- `full` out 1: `rec_count*WORDS_PER_REC == RAM_DEPTH`.

## Operation
State machine:
- **IDLE**
  - `rec_ready = !full`.
  - On `rec_valid && rec_ready`: latch all 8 words into an internal buffer, set word index `k=0`, set `base = rec_count*8`, go to WRITE.
  - `clear` in IDLE sets `rec_count=0`. If `clear` and `rec_valid` arrive in the same cycle, `clear` wins and the record is not accepted that cycle.
- **WRITE**
  - Drive `mem_cs=1`, `mem_we=1`, `mem_addr=base+k`, `mem_data=buf[k]` for exactly one cycle.
  - Go to ACK.
- **ACK**
  - `mem_cs=0`, `mem_we=0`; `mem_addr` and `mem_data` hold their values.
  - Wait for `mem_write_done=1`.
    - If `k<7`: `k=k+1`, go to WRITE.
    - If `k==7`: `rec_count=rec_count+1`, pulse `rec_done`, go to IDLE.
  - No timeout; the writer waits indefinitely.
- Outside WRITE, `mem_cs` and `mem_we` are always 0. `mem_write_done` is ignored outside ACK.
- Buffered words are immune to `rec_word*` changes after acceptance.
- `rec_ready` is 0 in WRITE and ACK; incoming records are back-pressured, never dropped.
- Address arithmetic is in `ADDR_WIDTH` bits. `base+k` never exceeds `RAM_DEPTH-1`, because acceptance is blocked at `full`. There is no wrap-around.
- `clear` in WRITE or ACK is ignored; it has no queued effect.

## Timing
- Reset values: `mem_cs=0`, `mem_we=0`, `mem_addr=0`, `mem_data=0`, `rec_ready=1`, `rec_done=0`, `rec_count=0`, `full=0`; state IDLE; `k=0`.
- Reset mid-record discards the buffered record. `mem_cs` and `mem_we` are low in the first cycle after the reset edge, and no partial record is counted.
- All outputs are registered.
- `rec_ready` is a registered function of state and `full`. It is low from the cycle after acceptance until the cycle after `rec_done`.
- With acceptance at edge E0 and the memory acking one cycle after each write:
  - Word k is driven in cycle 1+2k after E0.
  - Its ack is seen in cycle 2+2k.
  - `rec_done` is high in cycle 17.
  - `rec_count` increments and `rec_ready` returns high in cycle 17.
  - The next acceptance is possible at the end of cycle 17.
- Throughput: 17 cycles per record with a one-cycle ack.
- `full` updates in the same cycle as `rec_count`.

## Structure
- Shared package `dcollide_mem_pkg` holds:
  - constants `DATA_WIDTH`, `WORDS_PER_REC`, `RAM_DEPTH`;
  - the writer state encoding (IDLE/WRITE/ACK).
- The same package is to be reused by the read-side consumer.
- Single module, no sub-module. The 8-word buffer is an internal register array.

## Test plan
- **Reset:** hold `rst` 2 cycles → all outputs at their reset values and `rec_ready=1`. Then assert `rst` during ACK of word 3 → `mem_we=0` next cycle and `rec_count=0`.
- **Single record:** words `0x11`…`0x18` accepted at E0 → writes at addr 0..7 with matching data, each `mem_we` pulse one cycle wide, `rec_done` in cycle 17, `rec_count=1`.
- **Fill:** 4 back-to-back records into `RAM_DEPTH=32` → last write at addr 31, `full=1`, `rec_ready=0`; a 5th `rec_valid` held for 20 cycles is never accepted and `mem_cs` stays 0.
- **Clear:** after fill, pulse `clear` in IDLE → `rec_count=0` and `full=0`; the next record writes addr 0..7. `clear` during ACK → no effect.
- **Slow ack:** delay `mem_write_done` 3 cycles for word 5 → the writer holds in ACK with `mem_addr=5` stable, no extra `mem_we` pulses, `rec_done` 3 cycles later than nominal.
- **Back-pressure:** `rec_valid` held high and `rec_word*` changed during a transfer → only the first record's values are written, and the second record is accepted after `rec_done`.
